// File: rtl/cim_tile_seq_if.sv
// cim_tile_seq_if: job control, weight/input/result streams, CIM command port and perf counters.
interface cim_tile_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 4,
    parameter int KT_W   = 8
);
    logic              start;
    logic [KT_W-1:0]   cfg_ktiles;
    logic [REG_W:0]    cfg_nvec;
    logic              busy, done, err_cfg;
    logic              w_valid, w_ready;
    logic [DATA_W-1:0] w_data;
    logic              x_valid, x_ready;
    logic [DATA_W-1:0] x_data;
    logic              o_valid, o_ready;
    logic [DATA_W-1:0] o_data;
    logic [REG_W-1:0]  o_idx;
    logic              write, cim, partial_sum, reset_output;
    logic [REG_W-1:0]  output_reg;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] cim_output;
    logic [31:0]       perf_cycles, perf_stalls;

    modport master (
        input  start, cfg_ktiles, cfg_nvec, w_valid, w_data, x_valid, x_data, o_ready, cim_output,
        output busy, done, err_cfg, w_ready, x_ready, o_valid, o_data, o_idx,
               write, cim, partial_sum, reset_output, output_reg, address, input_data,
               perf_cycles, perf_stalls
    );
    modport slave (
        output start, cfg_ktiles, cfg_nvec, w_valid, w_data, x_valid, x_data, o_ready, cim_output,
        input  busy, done, err_cfg, w_ready, x_ready, o_valid, o_data, o_idx,
               write, cim, partial_sum, reset_output, output_reg, address, input_data,
               perf_cycles, perf_stalls
    );
endinterface

// File: rtl/cim_tile_seq.sv
// cim_tile_seq: tile sequencer driving the CIM macro from weight/input streams and draining results.
// Busy-cycle and stall counters are built only when CIM_SEQ_PERF_EN is defined.
module cim_tile_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WROWS  = 32,
    parameter int REG_W  = 4,
    parameter int RD_LAT = 1,
    parameter int KT_W   = 8
) (
    input logic            CLK,
    input logic            RES,
    cim_tile_seq_if.master bus
);
    localparam int RW = WROWS > 1 ? $clog2(WROWS) : 1;
    localparam int LW = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
    localparam logic [REG_W:0] NMAX = {1'b1, {REG_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN, RD, OUT} state_t;

    typedef struct packed {
        state_t            st;
        logic              busy, done, err, write, cim, psum, rst_o, ovalid;
        logic [REG_W-1:0]  oreg, oidx, v;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din, odata;
        logic [RW-1:0]     row;
        logic [KT_W-1:0]   kt, kt_q;
        logic [REG_W:0]    nv_q;
        logic [LW-1:0]     lat;
    } regs_t;

    regs_t r, n;
    logic  ok, v_last, kt_last, row_last;

    assign ok       = bus.cfg_ktiles != '0 && bus.cfg_nvec != '0 && bus.cfg_nvec <= NMAX;
    assign v_last   = {1'b0, r.v} + 1'b1 == r.nv_q;
    assign kt_last  = r.kt + 1'b1 == r.kt_q;
    assign row_last = r.row == RW'(WROWS - 1);

    always_ff @(posedge CLK) r <= RES ? '0 : n;

    always_comb begin
        n       = r;
        n.write = 1'b0;
        n.cim   = 1'b0;
        n.psum  = 1'b0;
        n.rst_o = 1'b0;
        n.done  = 1'b0;
        case (r.st)
            IDLE: if (bus.start) begin
                n.st    = ok ? CLEAR : IDLE;
                n.busy  = ok;
                n.rst_o = ok;
                n.err   = !ok;
                n.done  = !ok;
                n.kt_q  = bus.cfg_ktiles;
                n.nv_q  = bus.cfg_nvec;
                n.kt    = '0;
                n.row   = '0;
                n.v     = '0;
            end
            CLEAR: n.st = LOAD_W;
            LOAD_W: if (bus.w_valid) begin
                n.write = 1'b1;
                n.addr  = ADDR_W'(r.row);
                n.din   = bus.w_data;
                n.row   = row_last ? '0 : r.row + 1'b1;
                n.st    = row_last ? COMPUTE : LOAD_W;
            end
            COMPUTE: if (bus.x_valid) begin
                n.cim  = 1'b1;
                n.oreg = r.v;
                n.din  = bus.x_data;
                n.psum = r.kt != '0;
                n.v    = v_last ? '0 : r.v + 1'b1;
                n.kt   = v_last ? r.kt + 1'b1 : r.kt;
                n.st   = !v_last ? COMPUTE : kt_last ? DRAIN : LOAD_W;
            end
            // One idle cycle separates the last cim strobe from the first read select
            DRAIN: begin
                n.oreg = r.v;
                n.lat  = '0;
                n.st   = RD;
            end
            RD: begin
                n.lat = r.lat + 1'b1;
                if (r.lat == LW'(RD_LAT)) begin
                    n.ovalid = 1'b1;
                    n.odata  = bus.cim_output;
                    n.oidx   = r.v;
                    n.st     = OUT;
                end
            end
            OUT: if (bus.o_ready) begin
                n.ovalid = 1'b0;
                n.v      = v_last ? '0 : r.v + 1'b1;
                n.st     = v_last ? IDLE : DRAIN;
                n.done   = v_last;
                n.busy   = !v_last;
            end
            default: n.st = IDLE;
        endcase
    end

    assign bus.busy         = r.busy;
    assign bus.done         = r.done;
    assign bus.err_cfg      = r.err;
    assign bus.w_ready      = r.st == LOAD_W;
    assign bus.x_ready      = r.st == COMPUTE;
    assign bus.o_valid      = r.ovalid;
    assign bus.o_data       = r.odata;
    assign bus.o_idx        = r.oidx;
    assign bus.write        = r.write;
    assign bus.cim          = r.cim;
    assign bus.partial_sum  = r.psum;
    assign bus.reset_output = r.rst_o;
    assign bus.output_reg   = r.oreg;
    assign bus.address      = r.addr;
    assign bus.input_data   = r.din;

`ifdef CIM_SEQ_PERF_EN
    logic [31:0] pc, ps;
    logic        stall;

    assign stall = (r.st == LOAD_W && !bus.w_valid) || (r.st == COMPUTE && !bus.x_valid) ||
                   (r.ovalid && !bus.o_ready);

    always_ff @(posedge CLK)
        if (RES || (r.st == IDLE && bus.start && ok)) begin
            pc <= '0;
            ps <= '0;
        end else if (r.busy) begin
            pc <= pc + {31'd0, pc != '1};
            ps <= ps + {31'd0, stall && ps != '1};
        end

    assign bus.perf_cycles = pc;
    assign bus.perf_stalls = ps;
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_cim_tile_seq.sv
// tb_cim_tile_seq: directed bench with a behavioural CIM macro and stream drivers around cim_tile_seq.
module tb_cim_tile_seq;
    localparam int DATA_W = 32, ADDR_W = 32, WROWS = 32, REG_W = 4, RD_LAT = 1, KT_W = 8;

    logic CLK = 1'b0;
    logic RES = 1'b1;
    int   passed = 0, total = 0;
    int   n_wr = 0, n_cim = 0, n_ps = 0, n_rst = 0, n_done = 0, n_bad = 0;
    int   ea = 0, ci = 0, cur_nvec = 1;
    logic [31:0] wmem [WROWS];
    logic [31:0] acc [16];

    always #5 CLK = ~CLK;

    cim_tile_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .KT_W(KT_W)) bus ();

    cim_tile_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WROWS(WROWS), .REG_W(REG_W),
                   .RD_LAT(RD_LAT), .KT_W(KT_W)) dut (.CLK(CLK), .RES(RES), .bus(bus));

    function automatic logic [31:0] f(input logic [31:0] w, input logic [31:0] x, input int r);
        return w ^ (x + 32'(r));
    endfunction

    function automatic logic [31:0] mdot(input logic [31:0] x);
        logic [31:0] s = '0;
        for (int r = 0; r < WROWS; r++) s += f(wmem[r], x, r);
        return s;
    endfunction

    function automatic logic [31:0] gw(input int seed, input int t, input int r);
        return 32'(seed + t * 37 + r) * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] gx(input int seed, input int t, input int v);
        return 32'(seed + t * 101 + v * 7 + 3) * 32'h85EBCA77;
    endfunction

    function automatic logic [31:0] expv(input int seed, input int kt, input int v);
        logic [31:0] s = '0;
        for (int t = 0; t < kt; t++)
            for (int r = 0; r < WROWS; r++) s += f(gw(seed, t, r), gx(seed, t, v), r);
        return s;
    endfunction

    // Behavioural macro: one-cycle registered read of the selected output register
    always @(posedge CLK) begin
        if (bus.write) wmem[bus.address[4:0]] <= bus.input_data;
        if (bus.reset_output) for (int i = 0; i < 16; i++) acc[i] <= '0;
        else if (bus.cim)
            acc[bus.output_reg] <= (bus.partial_sum ? acc[bus.output_reg] : '0) + mdot(bus.input_data);
        bus.cim_output <= acc[bus.output_reg];
    end

    always @(negedge CLK) if (!RES) begin
        if (bus.reset_output) begin n_rst++; ea = 0; ci = 0; end
        if (bus.write) begin
            n_wr++;
            if (bus.address !== ADDR_W'(ea)) n_bad++;
            ea = (ea + 1) % WROWS;
        end
        if (bus.cim) begin
            n_cim++;
            if (bus.partial_sum) n_ps++;
            if (32'(bus.output_reg) !== 32'(ci % cur_nvec)) n_bad++;
            ci++;
        end
        if (int'(bus.write) + int'(bus.cim) + int'(bus.reset_output) > 1) n_bad++;
        if (bus.done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic timeout(input string tag, input int t);
        total++;
        $error("FAIL %s timeout: waited %0d cycles, expected < 200", tag, t);
    endtask

    task automatic send_w(input logic [31:0] d, input int gap);
        int t = 0;
        if (gap > 0) begin
            bus.w_valid = 1'b0;
            while (!bus.w_ready && t < 200) begin @(negedge CLK); t++; end
            repeat (gap) @(negedge CLK);
        end
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        while (!bus.w_ready && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) timeout("w_ready", t);
        @(negedge CLK);
        bus.w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [31:0] d, input int gap);
        int t = 0;
        if (gap > 0) begin
            bus.x_valid = 1'b0;
            while (!bus.x_ready && t < 200) begin @(negedge CLK); t++; end
            repeat (gap) @(negedge CLK);
        end
        bus.x_valid = 1'b1;
        bus.x_data  = d;
        while (!bus.x_ready && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) timeout("x_ready", t);
        @(negedge CLK);
        bus.x_valid = 1'b0;
    endtask

    task automatic recv(input int idx, input logic [31:0] d, input int hold);
        int t = 0;
        bus.o_ready = (hold == 0);
        while (!bus.o_valid && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) timeout("o_valid", t);
        chk($sformatf("o_idx[%0d]", idx), 64'(bus.o_idx), 64'(idx));
        chk($sformatf("o_data[%0d]", idx), 64'(bus.o_data), 64'(d));
        repeat (hold) begin
            @(negedge CLK);
            chk("stall o_valid", 64'(bus.o_valid), 64'(1));
            chk("stall o_idx", 64'(bus.o_idx), 64'(idx));
            chk("stall o_data", 64'(bus.o_data), 64'(d));
        end
        bus.o_ready = 1'b1;
        @(negedge CLK);
    endtask

    task automatic start_job(input int kt, input int nv);
        cur_nvec       = nv;
        bus.cfg_ktiles = KT_W'(kt);
        bus.cfg_nvec   = (REG_W + 1)'(nv);
        bus.start      = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic run_job(input int seed, input int kt, input int nv, input bit gaps,
                           input int hold_idx, input bit pulse, output int stalls);
        int g;
        stalls = 0;
        start_job(kt, nv);
        chk("busy after start", 64'(bus.busy), 64'(1));
        chk("err_cfg cleared", 64'(bus.err_cfg), 64'(0));
        for (int t = 0; t < kt; t++) begin
            for (int r = 0; r < WROWS; r++) begin
                g = (gaps && r % 5 == 2) ? 2 : 0;
                if (pulse && t == 0 && r == 5) begin
                    bus.cfg_nvec = '0;
                    bus.start    = 1'b1;
                    @(negedge CLK);
                    bus.start = 1'b0;
                end
                send_w(gw(seed, t, r), g);
                stalls += g;
            end
            for (int v = 0; v < nv; v++) begin
                g = (gaps && v % 2 == 1) ? 1 : 0;
                send_x(gx(seed, t, v), g);
                stalls += g;
            end
        end
        for (int v = 0; v < nv; v++) begin
            recv(v, expv(seed, kt, v), v == hold_idx ? 5 : 0);
            stalls += (v == hold_idx) ? 5 : 0;
        end
        chk("done at end", 64'(bus.done), 64'(1));
        chk("busy at end", 64'(bus.busy), 64'(0));
        @(negedge CLK);
        chk("done one cycle", 64'(bus.done), 64'(0));
    endtask

    initial begin
        int st, w0, c0, p0, r0, d0, b0;
        int bad_kt [3] = '{1, 1, 0};
        int bad_nv [3] = '{0, 17, 4};
        bus.start = 1'b0; bus.cfg_ktiles = '0; bus.cfg_nvec = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.x_valid = 1'b0; bus.x_data = '0;
        bus.o_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst busy/done/err", 64'({bus.busy, bus.done, bus.err_cfg}), 64'(0));
        chk("rst readies/valid", 64'({bus.w_ready, bus.x_ready, bus.o_valid}), 64'(0));
        chk("rst strobes", 64'({bus.write, bus.cim, bus.partial_sum, bus.reset_output}), 64'(0));
        chk("rst output_reg/o_idx", 64'({bus.output_reg, bus.o_idx}), 64'(0));
        chk("rst address", 64'(bus.address), 64'(0));
        chk("rst input_data/o_data", {bus.input_data, bus.o_data}, 64'(0));
        chk("rst perf", {bus.perf_cycles, bus.perf_stalls}, 64'(0));
        RES = 1'b0;
        @(negedge CLK);

        w0 = n_wr; c0 = n_cim; p0 = n_ps; r0 = n_rst; d0 = n_done; b0 = n_bad;
        run_job(11, 1, 2, 1'b0, -1, 1'b0, st);
        chk("j1 resets", 64'(n_rst - r0), 64'(1));
        chk("j1 writes", 64'(n_wr - w0), 64'(32));
        chk("j1 cims", 64'(n_cim - c0), 64'(2));
        chk("j1 psums", 64'(n_ps - p0), 64'(0));
        chk("j1 dones", 64'(n_done - d0), 64'(1));
        chk("j1 addr/oreg/excl", 64'(n_bad - b0), 64'(0));

        w0 = n_wr; c0 = n_cim; p0 = n_ps; r0 = n_rst; d0 = n_done; b0 = n_bad;
        run_job(500, 3, 16, 1'b0, -1, 1'b1, st);
        chk("j2 resets", 64'(n_rst - r0), 64'(1));
        chk("j2 writes", 64'(n_wr - w0), 64'(96));
        chk("j2 cims", 64'(n_cim - c0), 64'(48));
        chk("j2 psums", 64'(n_ps - p0), 64'(32));
        chk("j2 dones", 64'(n_done - d0), 64'(1));
        chk("j2 addr/oreg/excl", 64'(n_bad - b0), 64'(0));
        chk("j2 busy start ignored", 64'(bus.err_cfg), 64'(0));

        for (int i = 0; i < 3; i++) begin
            w0 = n_wr; c0 = n_cim; r0 = n_rst; d0 = n_done;
            start_job(bad_kt[i], bad_nv[i]);
            chk($sformatf("bad%0d err_cfg", i), 64'(bus.err_cfg), 64'(1));
            chk($sformatf("bad%0d done", i), 64'(bus.done), 64'(1));
            chk($sformatf("bad%0d busy", i), 64'(bus.busy), 64'(0));
            @(negedge CLK);
            chk($sformatf("bad%0d done drop", i), 64'(bus.done), 64'(0));
            chk($sformatf("bad%0d err sticky", i), 64'(bus.err_cfg), 64'(1));
            @(negedge CLK);
            chk($sformatf("bad%0d strobes", i), 64'(n_wr - w0 + n_cim - c0 + n_rst - r0), 64'(0));
            chk($sformatf("bad%0d dones", i), 64'(n_done - d0), 64'(1));
        end

        w0 = n_wr; c0 = n_cim; p0 = n_ps; d0 = n_done; b0 = n_bad;
        run_job(2024, 2, 5, 1'b1, 3, 1'b0, st);
        chk("j3 writes", 64'(n_wr - w0), 64'(64));
        chk("j3 cims", 64'(n_cim - c0), 64'(10));
        chk("j3 psums", 64'(n_ps - p0), 64'(5));
        chk("j3 dones", 64'(n_done - d0), 64'(1));
        chk("j3 addr/oreg/excl", 64'(n_bad - b0), 64'(0));
`ifdef CIM_SEQ_PERF_EN
        chk("perf_stalls", 64'(bus.perf_stalls), 64'(st));
`else
        chk("perf tied off", {bus.perf_cycles, bus.perf_stalls}, 64'(0));
`endif

        start_job(1, 4);
        for (int r = 0; r < WROWS; r++) send_w(gw(77, 0, r), 0);
        send_x(gx(77, 0, 0), 0);
        send_x(gx(77, 0, 1), 0);
        RES = 1'b1;
        @(negedge CLK);
        chk("abort busy/done", 64'({bus.busy, bus.done}), 64'(0));
        chk("abort strobes", 64'({bus.write, bus.cim, bus.reset_output}), 64'(0));
        chk("abort ready/valid", 64'({bus.w_ready, bus.x_ready, bus.o_valid}), 64'(0));
        RES = 1'b0;
        @(negedge CLK);
        w0 = n_wr; c0 = n_cim; p0 = n_ps; r0 = n_rst; d0 = n_done; b0 = n_bad;
        run_job(99, 2, 4, 1'b0, -1, 1'b0, st);
        chk("j4 resets", 64'(n_rst - r0), 64'(1));
        chk("j4 writes", 64'(n_wr - w0), 64'(64));
        chk("j4 cims", 64'(n_cim - c0), 64'(8));
        chk("j4 psums", 64'(n_ps - p0), 64'(4));
        chk("j4 dones", 64'(n_done - d0), 64'(1));
        chk("j4 addr/oreg/excl", 64'(n_bad - b0), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
